flags_psr_stack: RTL and testbench

- Parametrised processor-status/flags register for the CR16-style datapath. Successor to the plain 5-bit flag latch.
- Adds per-bit write enables and a LIFO save/restore stack of flag words for interrupt/call context.
- Adds a combinational condition-code evaluator that drives the branch/jump decision.
- Sits between the ALU flag outputs and the control FSM.

---
 rtl/flags_psr_stack.sv | 115 +++++++++++
 tb/tb_flags_psr_stack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/flags_psr_stack.sv
// rtl/flags_psr_stack.sv - flags/PSR register with per-bit write enables, LIFO save stack and condition evaluator
// Optional feature macro: FLAGS_STICKY_F_EN (F bit sticky under masked writes)
module flags_psr_stack #(
    parameter int FLAG_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] flags_we,
    input  logic              push,
    input  logic              pop,
    input  logic [3:0]        cond,
    output logic [FLAG_W-1:0] flags_out,
    output logic              cond_true,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              stack_err
);
    localparam int                PTR_W    = $clog2(STACK_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] r_stack [STACK_DEPTH];
    logic [CNT_W-1:0]  r_depth;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic [PTR_W-1:0]  w_push_idx;
    logic [PTR_W-1:0]  w_top_idx;
    logic [FLAG_W-1:0] w_written;
    logic              w_c, w_l, w_f, w_z, w_n;

    assign w_full     = (r_depth == CNT_FULL);
    assign w_empty    = (r_depth == '0);
    assign w_push_idx = r_depth[PTR_W-1:0];
    assign w_top_idx  = r_depth[PTR_W-1:0] - PTR_ONE;

    always_comb begin
        w_written = (r_flags & ~flags_we) | (flags_in & flags_we);
`ifdef FLAGS_STICKY_F_EN
        w_written[2] = r_flags[2] | (flags_we[2] & flags_in[2]);
`else
        w_written[2] = flags_we[2] ? flags_in[2] : r_flags[2];
`endif
    end

    // A successful pop (or swap) restores the top word and overrides any masked write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else if (pop && !w_empty) begin
            r_flags <= r_stack[w_top_idx];
            if (push) begin
                r_stack[w_top_idx] <= r_flags;
            end else begin
                r_depth <= r_depth - CNT_ONE;
            end
        end else begin
            r_flags <= w_written;
            if (push) begin
                if (!w_full) begin
                    r_stack[w_push_idx] <= r_flags;
                    r_depth             <= r_depth + CNT_ONE;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (pop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_c = r_flags[0];
    assign w_l = r_flags[1];
    assign w_f = r_flags[2];
    assign w_z = r_flags[3];
    assign w_n = r_flags[4];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = w_z;
            4'b0001: cond_true = !w_z;
            4'b0010: cond_true = w_c;
            4'b0011: cond_true = !w_c;
            4'b0100: cond_true = w_l;
            4'b0101: cond_true = !w_l;
            4'b0110: cond_true = w_n;
            4'b0111: cond_true = !w_n;
            4'b1000: cond_true = w_f;
            4'b1001: cond_true = !w_f;
            4'b1010: cond_true = !w_l && !w_z;
            4'b1011: cond_true = w_l || w_z;
            4'b1100: cond_true = !w_n && !w_z;
            4'b1101: cond_true = w_n || w_z;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign flags_out = r_flags;
    assign depth     = r_depth;
    assign full      = w_full;
    assign empty     = w_empty;
    assign stack_err = r_err;

endmodule

// File: tb/tb_flags_psr_stack.sv
// tb/tb_flags_psr_stack.sv - self-checking bench for flags_psr_stack against a queue-based reference model
module tb_flags_psr_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] flags_in = '0;
    logic [4:0] flags_we = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] cond = '0;
    logic [4:0] flags_out;
    logic       cond_true;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       stack_err;

    int total = 0;
    int bad   = 0;

    logic [4:0] m_flags;
    logic [4:0] m_q[$];
    logic       m_err;

    flags_psr_stack dut (
        .clk(clk), .reset(reset), .flags_in(flags_in), .flags_we(flags_we),
        .push(push), .pop(pop), .cond(cond), .flags_out(flags_out),
        .cond_true(cond_true), .depth(depth), .full(full), .empty(empty),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Condition meaning: codes 0..9 pick one flag, odd codes invert it; 10..13 are compound tests.
    function automatic logic ref_cond(input logic [4:0] f, input logic [3:0] c);
        logic [4:0] pick;
        logic c_f, l_f, z_f, n_f;
        c_f = f[0]; l_f = f[1]; z_f = f[3]; n_f = f[4];
        pick = {f[2], f[4], f[1], f[0], f[3]};
        if (c < 4'd10) return pick[c[3:1]] ^ c[0];
        if (c == 4'd10) return !(l_f || z_f);
        if (c == 4'd11) return l_f || z_f;
        if (c == 4'd12) return !(n_f || z_f);
        if (c == 4'd13) return n_f || z_f;
        return (c == 4'd14);
    endfunction

    task automatic model_apply(input logic rst, input logic [4:0] fin, input logic [4:0] we,
                               input logic pu, input logic po);
        logic [4:0] nxt;
        logic [4:0] top;
        if (rst) begin
            m_flags = '0; m_q.delete(); m_err = 1'b0;
            return;
        end
        nxt = (m_flags & ~we) | (fin & we);
`ifdef FLAGS_STICKY_F_EN
        if (m_flags[2]) nxt[2] = 1'b1;
`endif
        if (po && m_q.size() > 0) begin
            top = m_q[$];
            if (pu) m_q[$] = m_flags;
            else void'(m_q.pop_back());
            m_flags = top;
        end else begin
            if (pu) begin
                if (m_q.size() < 4) m_q.push_back(m_flags);
                else m_err = 1'b1;
            end else if (po) begin
                m_err = 1'b1;
            end
            m_flags = nxt;
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] fin, input logic [4:0] we,
                        input logic pu, input logic po);
        reset = rst; flags_in = fin; flags_we = we; push = pu; pop = po;
        @(posedge clk);
        model_apply(rst, fin, we, pu, po);
        #1;
        reset = 1'b0; flags_we = '0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 5'h1F, 5'h1F, 1'b1, 1'b0);
        step(1'b1, 5'h1F, 5'h1F, 1'b1, 1'b1);
        total++; if (flags_out !== 5'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", flags_out); end
        total++; if (depth !== 3'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        total++; if ({empty, full, stack_err} !== 3'b100) begin bad++; $display("FAIL reset_status got=%b exp=100", {empty, full, stack_err}); end
    endtask

    task automatic test_masked_write();
        step(1'b0, 5'h1F, 5'h0A, 1'b0, 1'b0);
        total++; if (flags_out !== 5'h0A) begin bad++; $display("FAIL masked_write got=%h exp=0a", flags_out); end
        cond = 4'b0000; #1;
        total++; if (cond_true !== 1'b1) begin bad++; $display("FAIL cond_eq got=%b exp=1", cond_true); end
        cond = 4'b1111; #1;
        total++; if (cond_true !== 1'b0) begin bad++; $display("FAIL cond_never got=%b exp=0", cond_true); end
    endtask

    task automatic test_push_pop();
        step(1'b0, 5'h08, 5'h1F, 1'b0, 1'b0);
        step(1'b0, 5'h01, 5'h1F, 1'b1, 1'b0);
        total++; if (flags_out !== 5'h01 || depth !== 3'd1) begin bad++; $display("FAIL push_write got=%h/%0d exp=01/1", flags_out, depth); end
        step(1'b0, 5'h1F, 5'h1F, 1'b0, 1'b1);
        total++; if (flags_out !== 5'h08 || depth !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL pop_restore got=%h/%0d/%b exp=08/0/1", flags_out, depth, empty); end
    endtask

    task automatic test_full();
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 5'(i + 3), 5'h1F, 1'b1, 1'b0);
        total++; if (full !== 1'b1 || depth !== 3'd4 || stack_err !== 1'b0) begin bad++; $display("FAIL fill got=%b/%0d/%b exp=1/4/0", full, depth, stack_err); end
        step(1'b0, 5'h11, 5'h1F, 1'b1, 1'b0);
        total++; if (depth !== 3'd4 || stack_err !== 1'b1 || flags_out !== 5'h11) begin bad++; $display("FAIL overflow got=%0d/%b/%h exp=4/1/11", depth, stack_err, flags_out); end
        step(1'b0, 5'h00, 5'h00, 1'b0, 1'b1);
        total++; if (flags_out !== 5'h05 || depth !== 3'd3) begin bad++; $display("FAIL pop_after_full got=%h/%0d exp=05/3", flags_out, depth); end
        step(1'b0, 5'h00, 5'h00, 1'b0, 1'b1);
        total++; if (flags_out !== 5'h04 || stack_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%h/%b exp=04/1", flags_out, stack_err); end
    endtask

    task automatic test_pop_empty();
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        step(1'b0, 5'h10, 5'h10, 1'b0, 1'b1);
        total++; if (flags_out !== 5'h10 || depth !== 3'd0 || stack_err !== 1'b1) begin bad++; $display("FAIL pop_empty got=%h/%0d/%b exp=10/0/1", flags_out, depth, stack_err); end
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        step(1'b0, 5'h07, 5'h1F, 1'b1, 1'b1);
        total++; if (flags_out !== 5'h07 || depth !== 3'd1 || stack_err !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%h/%0d/%b exp=07/1/0", flags_out, depth, stack_err); end
    endtask

    task automatic test_swap();
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        step(1'b0, 5'h04, 5'h1F, 1'b0, 1'b0);
        step(1'b0, 5'h02, 5'h1F, 1'b1, 1'b0);
        step(1'b0, 5'h1F, 5'h1F, 1'b1, 1'b1);
        total++; if (flags_out !== 5'h04 || depth !== 3'd1 || stack_err !== 1'b0) begin bad++; $display("FAIL swap got=%h/%0d/%b exp=04/1/0", flags_out, depth, stack_err); end
        step(1'b0, 5'h00, 5'h00, 1'b0, 1'b1);
        total++; if (flags_out !== 5'h02 || depth !== 3'd0) begin bad++; $display("FAIL swap_top got=%h/%0d exp=02/0", flags_out, depth); end
    endtask

    task automatic test_sticky_f();
        logic exp_f;
        logic exp_fc;
`ifdef FLAGS_STICKY_F_EN
        exp_f = 1'b1; exp_fc = 1'b0;
`else
        exp_f = 1'b0; exp_fc = 1'b1;
`endif
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        step(1'b0, 5'h04, 5'h04, 1'b0, 1'b0);
        step(1'b0, 5'h00, 5'h04, 1'b0, 1'b0);
        cond = 4'b1001; #1;
        total++; if (flags_out[2] !== exp_f) begin bad++; $display("FAIL f_write got=%b exp=%b", flags_out[2], exp_f); end
        total++; if (cond_true !== exp_fc) begin bad++; $display("FAIL cond_fc got=%b exp=%b", cond_true, exp_fc); end
    endtask

    task automatic test_random();
        logic [4:0] fin, we;
        logic pu, po, rst;
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            fin = 5'($urandom); we = 5'($urandom);
            pu  = ($urandom_range(0, 99) < 45);
            po  = ($urandom_range(0, 99) < 40);
            rst = ($urandom_range(0, 99) < 3);
            step(rst, fin, we, pu, po);
            cond = 4'($urandom); #1;
            total++;
            if (flags_out !== m_flags || depth !== 3'(m_q.size()) || stack_err !== m_err ||
                full !== (m_q.size() == 4) || empty !== (m_q.size() == 0)) begin
                bad++;
                $display("FAIL random_state n=%0d got=%h/%0d/%b/%b/%b exp=%h/%0d/%b", n, flags_out, depth,
                         stack_err, full, empty, m_flags, m_q.size(), m_err);
            end
            total++;
            if (cond_true !== ref_cond(m_flags, cond)) begin
                bad++;
                $display("FAIL random_cond n=%0d cond=%h got=%b exp=%b", n, cond, cond_true, ref_cond(m_flags, cond));
            end
        end
    endtask

    task automatic test_all_conds();
        for (int v = 0; v < 32; v++) begin
            step(1'b0, 5'(v), 5'h1F, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c); #1;
                total++;
                if (cond_true !== ref_cond(5'(v), 4'(c))) begin
                    bad++;
                    $display("FAIL cond_table flags=%h cond=%h got=%b exp=%b", v, c, cond_true, ref_cond(5'(v), 4'(c)));
                end
            end
        end
    endtask

    initial begin
        m_flags = '0; m_err = 1'b0;
        test_reset();
        test_masked_write();
        test_push_pop();
        test_full();
        test_pop_empty();
        test_swap();
        test_sticky_f();
        step(1'b1, 5'h00, 5'h00, 1'b0, 1'b0);
        test_all_conds();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
